axis_packet_arbiter: RTL and testbench

- Packet-atomic round-robin arbiter that merges NUM_SRC AXI-Stream sources into the single stream feeding the header adder.
- A granted source owns the output until its TLAST beat has been accepted, so packets are never interleaved.
- The winning source index is presented on AXIS_OUT_TID and held for the whole packet, so the downstream header adder can encode the origin channel.
- Output is fully registered: a single pipeline stage with no combinational path from AXIS_IN_TVALID to AXIS_OUT_TVALID.

---
 rtl/axis_packet_arbiter.sv | 148 ++++++++++++++
 tb/tb_axis_packet_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter.sv
// Packet-atomic round-robin AXI-Stream arbiter. Merges NUM_SRC sources into one
// registered output stream and tags every beat with its source index on TID.
module axis_packet_arbiter #(
  parameter int unsigned DW      = 512,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SRC*DW-1:0]   AXIS_IN_TDATA,
  input  logic [NUM_SRC-1:0]      AXIS_IN_TVALID,
  output logic [NUM_SRC-1:0]      AXIS_IN_TREADY,
  input  logic [NUM_SRC*DW/8-1:0] AXIS_IN_TKEEP,
  input  logic [NUM_SRC-1:0]      AXIS_IN_TLAST,
  output logic [DW-1:0]           AXIS_OUT_TDATA,
  output logic                    AXIS_OUT_TVALID,
  input  logic                    AXIS_OUT_TREADY,
  output logic [DW/8-1:0]         AXIS_OUT_TKEEP,
  output logic                    AXIS_OUT_TLAST,
  output logic [IDW-1:0]          AXIS_OUT_TID,
  output logic [31:0]             PKT_COUNT
);

  localparam int unsigned KW = DW / 8;

  typedef enum logic {StIdle, StPass} state_e;

  state_e         r_state, w_state_nxt;
  logic [IDW-1:0] r_grant, w_grant_nxt;
  logic [IDW-1:0] r_ptr, w_ptr_nxt;
  logic [IDW-1:0] w_sel, w_sel_hi, w_sel_lo;
  logic           w_any, w_hit_hi;
  logic           w_g_valid, w_g_last;
  logic [DW-1:0]  w_g_data;
  logic [KW-1:0]  w_g_keep;
  logic           w_out_free, w_hs, w_pkt_done;

  logic [DW-1:0]  r_tdata;
  logic [KW-1:0]  r_tkeep;
  logic           r_tlast, r_tvalid;
  logic [IDW-1:0] r_tid;
  logic [31:0]    r_pkt_count;

  // Circular search from r_ptr: prefer the lowest requester at or above r_ptr,
  // otherwise wrap to the lowest requester overall.
  always_comb begin
    w_any    = 1'b0;
    w_hit_hi = 1'b0;
    w_sel_hi = '0;
    w_sel_lo = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (AXIS_IN_TVALID[i]) begin
        w_any = 1'b1;
        if (IDW'(i) >= r_ptr) begin
          w_hit_hi = 1'b1;
          w_sel_hi = IDW'(i);
        end else begin
          w_sel_lo = IDW'(i);
        end
      end
    end
    w_sel = w_hit_hi ? w_sel_hi : w_sel_lo;
  end

  assign w_out_free = !r_tvalid || AXIS_OUT_TREADY;

  always_comb begin
    w_g_valid      = 1'b0;
    w_g_last       = 1'b0;
    w_g_data       = '0;
    w_g_keep       = '0;
    AXIS_IN_TREADY = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (r_grant == IDW'(i)) begin
        w_g_valid         = AXIS_IN_TVALID[i];
        w_g_last          = AXIS_IN_TLAST[i];
        w_g_data          = AXIS_IN_TDATA[i*DW +: DW];
        w_g_keep          = AXIS_IN_TKEEP[i*KW +: KW];
        AXIS_IN_TREADY[i] = (r_state == StPass) && w_out_free;
      end
    end
  end

  assign w_hs       = (r_state == StPass) && w_g_valid && w_out_free;
  assign w_pkt_done = w_hs && w_g_last;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      StIdle: begin
        if (w_any) begin
          w_grant_nxt = w_sel;
          w_state_nxt = StPass;
        end
      end
      StPass: begin
        if (w_pkt_done) begin
          w_state_nxt = StIdle;
          // Wrap on NUM_SRC so unused index codes are never visited.
          w_ptr_nxt   = (r_grant == IDW'(NUM_SRC - 1)) ? '0 : r_grant + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_grant     <= '0;
      r_ptr       <= '0;
      r_pkt_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_pkt_done) r_pkt_count <= r_pkt_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tid    <= '0;
      r_tvalid <= 1'b0;
    end else if (w_hs) begin
      r_tdata  <= w_g_data;
      r_tkeep  <= w_g_keep;
      r_tlast  <= w_g_last;
      r_tid    <= r_grant;
      r_tvalid <= 1'b1;
    end else if (AXIS_OUT_TREADY) begin
      r_tvalid <= 1'b0;
    end
  end

  assign AXIS_OUT_TDATA  = r_tdata;
  assign AXIS_OUT_TKEEP  = r_tkeep;
  assign AXIS_OUT_TLAST  = r_tlast;
  assign AXIS_OUT_TID    = r_tid;
  assign AXIS_OUT_TVALID = r_tvalid;
  assign PKT_COUNT       = r_pkt_count;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: per-source packet queues drive the inputs and a
// queue-level round-robin model predicts the merged output stream.
module tb_axis_packet_arbiter;

  localparam int DW      = 512;
  localparam int NUM_SRC = 4;
  localparam int IDW     = 2;
  localparam int KW      = DW / 8;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [KW-1:0]  keep;
    logic           last;
    logic [IDW-1:0] tid;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_SRC*DW-1:0] in_tdata;
  logic [NUM_SRC-1:0]    in_tvalid;
  logic [NUM_SRC-1:0]    in_tready;
  logic [NUM_SRC*KW-1:0] in_tkeep;
  logic [NUM_SRC-1:0]    in_tlast;
  logic [DW-1:0]         out_tdata;
  logic                  out_tvalid;
  logic                  out_tready;
  logic [KW-1:0]         out_tkeep;
  logic                  out_tlast;
  logic [IDW-1:0]        out_tid;
  logic [31:0]           pkt_count;

  axis_packet_arbiter #(
    .DW      (DW),
    .NUM_SRC (NUM_SRC),
    .IDW     (IDW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .AXIS_IN_TDATA   (in_tdata),
    .AXIS_IN_TVALID  (in_tvalid),
    .AXIS_IN_TREADY  (in_tready),
    .AXIS_IN_TKEEP   (in_tkeep),
    .AXIS_IN_TLAST   (in_tlast),
    .AXIS_OUT_TDATA  (out_tdata),
    .AXIS_OUT_TVALID (out_tvalid),
    .AXIS_OUT_TREADY (out_tready),
    .AXIS_OUT_TKEEP  (out_tkeep),
    .AXIS_OUT_TLAST  (out_tlast),
    .AXIS_OUT_TID    (out_tid),
    .PKT_COUNT       (pkt_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  beat_t       src_q [NUM_SRC][$];
  logic        mid [NUM_SRC];
  int          gap_src = 0;
  int          gap_left = 0;
  int          m_ptr = 0;
  int unsigned m_pkts = 0;
  int          hs_iter[$];
  int          first_valid_iter;

  function automatic beat_t rand_beat(input logic last);
    beat_t b;
    for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
    b.keep = {$urandom, $urandom};
    b.last = last;
    b.tid  = '0;
    return b;
  endfunction

  task automatic add_pkt(input int src, input int nbeats);
    for (int k = 0; k < nbeats; k++) src_q[src].push_back(rand_beat(k == nbeats - 1));
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NUM_SRC; i++) begin
      src_q[i].delete();
      mid[i] = 1'b0;
    end
    in_tvalid = '0;
    gap_left  = 0;
  endtask

  // Queue-level model: pick the first non-empty source circularly from m_ptr,
  // emit its whole packet, advance the pointer past it.
  task automatic run_traffic(input string name, input int ready_mode, input int bubble_pct,
                             input int max_cycles);
    beat_t              m_q [NUM_SRC][$];
    beat_t              exp_q[$];
    beat_t              e, got;
    logic [NUM_SRC-1:0] in_hs;
    logic               prev_stall;
    logic [DW+KW+IDW+1:0] prev_beat;
    logic               pat [4];
    int                 idx, drain, nbeat;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < NUM_SRC; i++) m_q[i] = src_q[i];
    forever begin
      idx = -1;
      for (int k = 0; k < NUM_SRC; k++)
        if (idx < 0 && m_q[(m_ptr + k) % NUM_SRC].size() > 0) idx = (m_ptr + k) % NUM_SRC;
      if (idx < 0) break;
      do begin
        e     = m_q[idx].pop_front();
        e.tid = IDW'(idx);
        exp_q.push_back(e);
      end while (!e.last);
      m_ptr = (idx + 1) % NUM_SRC;
      m_pkts++;
    end

    hs_iter.delete();
    first_valid_iter = -1;
    in_hs      = '0;
    prev_stall = 1'b0;
    prev_beat  = '0;
    drain      = 0;
    nbeat      = 0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_SRC; i++) begin
        if (in_hs[i]) begin
          e      = src_q[i].pop_front();
          mid[i] = !e.last;
        end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        in_tvalid[i] = 1'b0;
        if (src_q[i].size() > 0) begin
          in_tvalid[i] = 1'b1;
          if (mid[i]) begin
            if (i == gap_src && gap_left > 0) begin
              in_tvalid[i] = 1'b0;
              gap_left--;
            end else if ($urandom_range(0, 99) < bubble_pct) begin
              in_tvalid[i] = 1'b0;
            end
          end
          in_tdata[i*DW +: DW] = src_q[i][0].data;
          in_tkeep[i*KW +: KW] = src_q[i][0].keep;
          in_tlast[i]          = src_q[i][0].last;
        end
      end
      case (ready_mode)
        0:       out_tready = 1'b1;
        1:       out_tready = ($urandom_range(0, 99) < 60);
        default: out_tready = pat[cyc % 4];
      endcase
      #1;
      in_hs = in_tvalid & in_tready;
      if (first_valid_iter < 0 && out_tvalid) first_valid_iter = cyc;

      if (prev_stall) begin
        n_cmp++;
        if ({out_tvalid, out_tdata, out_tkeep, out_tlast, out_tid} !== prev_beat) begin
          n_err++;
          $display("FAIL %s stall_hold cyc%0d: got valid=%0b tid=%0d data[63:0]=%h, required held valid=1 tid=%0d data[63:0]=%h",
                   name, cyc, out_tvalid, out_tid, out_tdata[63:0], prev_beat[IDW-1:0],
                   prev_beat[KW+IDW+1 +: 64]);
        end
      end
      if (out_tvalid && !out_tready) begin
        n_cmp++;
        if (in_tready !== '0) begin
          n_err++;
          $display("FAIL %s stall_in_ready cyc%0d: got %b, required 0000", name, cyc, in_tready);
        end
      end
      n_cmp++;
      if ($countones(in_tready) > 1) begin
        n_err++;
        $display("FAIL %s ready_onehot cyc%0d: got %b, required at most one bit", name, cyc,
                 in_tready);
      end

      if (out_tvalid && out_tready) begin
        hs_iter.push_back(cyc);
        n_cmp++;
        got = {out_tdata, out_tkeep, out_tlast, out_tid};
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL %s extra_beat cyc%0d: got tid=%0d data[63:0]=%h, required no beat",
                   name, cyc, out_tid, out_tdata[63:0]);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL %s beat%0d: got tid=%0d last=%0b keep=%h data[63:0]=%h, required tid=%0d last=%0b keep=%h data[63:0]=%h",
                     name, nbeat, got.tid, got.last, got.keep, got.data[63:0], e.tid, e.last,
                     e.keep, e.data[63:0]);
          end
        end
        nbeat++;
      end
      prev_stall = out_tvalid && !out_tready;
      prev_beat  = {out_tvalid, out_tdata, out_tkeep, out_tlast, out_tid};
      if (exp_q.size() == 0) drain++;
      if (drain > 3) break;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s timeout: got %0d beats outstanding, required 0", name, exp_q.size());
    end
    out_tready = 1'b1;
    n_cmp++;
    if (pkt_count !== m_pkts) begin
      n_err++;
      $display("FAIL %s pkt_count: got %0d, required %0d", name, pkt_count, m_pkts);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if (in_tready !== '0 || out_tvalid !== 1'b0 || out_tid !== '0 || pkt_count !== '0 ||
        out_tlast !== 1'b0 || out_tdata !== '0 || out_tkeep !== '0) begin
      n_err++;
      $display("FAIL %s outputs_zero: got in_ready=%b valid=%0b tid=%0d count=%0d last=%0b data[63:0]=%h, required all 0",
               name, in_tready, out_tvalid, out_tid, pkt_count, out_tlast, out_tdata[63:0]);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    in_tdata   = '0;
    in_tkeep   = '0;
    in_tlast   = '0;
    out_tready = 1'b0;
    clear_sources();
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset  = 1'b0;
    m_ptr  = 0;
    m_pkts = 0;
  endtask

  task automatic test_round_robin();
    clear_sources();
    add_pkt(0, 2);
    add_pkt(0, 2);
    for (int i = 1; i < NUM_SRC; i++) add_pkt(i, 2);
    run_traffic("round_robin", 0, 0, 200);
  endtask

  task automatic test_single_src();
    clear_sources();
    src_q[1].push_back('{data: DW'(64'hA), keep: '1, last: 1'b0, tid: '0});
    src_q[1].push_back('{data: DW'(64'hB), keep: '1, last: 1'b0, tid: '0});
    src_q[1].push_back('{data: DW'(64'hC), keep: '1, last: 1'b1, tid: '0});
    run_traffic("single_src", 0, 0, 100);
    n_cmp++;
    if (first_valid_iter != 2) begin
      n_err++;
      $display("FAIL single_src latency: got %0d cycles, required 2", first_valid_iter);
    end
  endtask

  task automatic test_stall();
    clear_sources();
    add_pkt(3, 6);
    run_traffic("stall", 2, 0, 200);
  endtask

  task automatic test_mid_drop();
    clear_sources();
    add_pkt(1, 1);
    run_traffic("mid_drop_setup", 0, 0, 100);
    gap_src  = 2;
    gap_left = 3;
    add_pkt(2, 4);
    add_pkt(0, 2);
    run_traffic("mid_drop", 0, 0, 200);
    clear_sources();
    add_pkt(1, 1);
    run_traffic("mid_drop_setup2", 0, 0, 100);
    gap_left = 3;
    add_pkt(2, 4);
    add_pkt(0, 2);
    add_pkt(3, 2);
    run_traffic("mid_drop_src3", 0, 0, 200);
  endtask

  task automatic test_wrap();
    clear_sources();
    add_pkt(2, 1);
    run_traffic("wrap_setup", 0, 0, 100);
    add_pkt(0, 2);
    add_pkt(2, 2);
    add_pkt(3, 2);
    run_traffic("wrap", 0, 0, 200);
  endtask

  task automatic test_back_to_back();
    clear_sources();
    for (int p = 0; p < 4; p++) add_pkt(1, 1);
    run_traffic("back_to_back", 0, 0, 100);
    n_cmp++;
    if (hs_iter.size() != 4) begin
      n_err++;
      $display("FAIL back_to_back beat_count: got %0d, required 4", hs_iter.size());
    end
    for (int k = 1; k < hs_iter.size(); k++) begin
      n_cmp++;
      if (hs_iter[k] - hs_iter[k-1] != 2) begin
        n_err++;
        $display("FAIL back_to_back spacing%0d: got %0d cycles, required 2", k,
                 hs_iter[k] - hs_iter[k-1]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      clear_sources();
      for (int i = 0; i < NUM_SRC; i++) begin
        int npk;
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) add_pkt(i, $urandom_range(1, 4));
      end
      if (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() == 0)
        add_pkt($urandom_range(0, NUM_SRC - 1), 1);
      run_traffic("random", 1, 30, 600);
    end
  endtask

  task automatic test_reset_mid();
    logic [NUM_SRC-1:0] hs;
    int acc;
    clear_sources();
    add_pkt(2, 4);
    hs         = '0;
    acc        = 0;
    out_tready = 1'b1;
    for (int c = 0; c < 40 && acc < 2; c++) begin
      @(negedge clk);
      if (hs[2]) begin
        src_q[2].delete(0);
        acc++;
      end
      in_tvalid = '0;
      if (acc < 2) begin
        in_tvalid[2]          = 1'b1;
        in_tdata[2*DW +: DW]  = src_q[2][0].data;
        in_tkeep[2*KW +: KW]  = src_q[2][0].keep;
        in_tlast[2]           = src_q[2][0].last;
      end
      #1;
      hs = in_tvalid & in_tready;
    end
    n_cmp++;
    if (acc != 2 || out_tvalid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid pre_reset: got beats=%0d valid=%0b, required beats=2 valid=1",
               acc, out_tvalid);
    end
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("reset_mid_async");
    clear_sources();
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    m_ptr  = 0;
    m_pkts = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check_all_zero("reset_mid_release");
    end
    add_pkt(3, 2);
    add_pkt(1, 3);
    add_pkt(0, 2);
    run_traffic("post_reset", 0, 0, 200);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single_src();
    test_stall();
    test_mid_drop();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
